btn_event_scheduler: RTL and testbench

Multi-button input controller that debounces `NUM_BTNS` raw push-buttons and turns each clean press into one event. It uses a single shared sample tick rather than a derived clock, so the whole block runs in one clock domain. Simultaneous presses are arbitrated round-robin into a small event FIFO, which downstream logic (menu FSMs, counters, display controllers) drains through a valid/ready handshake.

---
 rtl/btn_event_scheduler.sv | 150 +++++++++++++++
 tb/tb_btn_event_scheduler.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/btn_event_scheduler.sv
// Multi-button debouncer and event scheduler. Raw buttons are synchronized,
// sampled on a shared tick and debounced. Each clean press becomes a pending
// request, and requests are granted round-robin into a first-word
// fall-through event FIFO that is drained through a valid/ready handshake.
module btn_event_scheduler #(
  parameter int NUM_BTNS   = 4,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int SAMPLE_MS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_a_p,
  input  logic [NUM_BTNS-1:0]         button_in,
  output logic                        evt_valid,
  output logic [$clog2(NUM_BTNS)-1:0] evt_id,
  input  logic                        evt_ready,
  output logic [NUM_BTNS-1:0]         btn_level,
  output logic                        ovf
);

  localparam int TICK_DIV = CLK_FREQ / 1000 * SAMPLE_MS;
  localparam int CNT_W    = $clog2(TICK_DIV);
  localparam int ID_W     = $clog2(NUM_BTNS);
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int FCNT_W   = PTR_W + 1;

  logic [CNT_W-1:0]    tick_cnt;
  logic                tick;
  logic [NUM_BTNS-1:0] sync_a;
  logic [NUM_BTNS-1:0] sync_b;
  logic [NUM_BTNS-1:0] s1;
  logic [NUM_BTNS-1:0] s2;
  logic [NUM_BTNS-1:0] agree;
  logic [NUM_BTNS-1:0] press;
  logic [NUM_BTNS-1:0] pending;
  logic [ID_W-1:0]     last_grant;

  logic                grant_vld;
  logic [ID_W-1:0]     grant_id;
  logic [NUM_BTNS-1:0] grant_mask;
  logic [ID_W-1:0]     cand;

  logic [ID_W-1:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [FCNT_W-1:0]   count;
  logic                full;
  logic                push;
  logic                pop;

  // Sample tick: one-cycle strobe at the last count of each period.
  assign tick = (tick_cnt == CNT_W'(TICK_DIV - 1));

  // Free-running tick counter, wraps after TICK_DIV cycles.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst_a_p || tick) tick_cnt <= '0;
    else                 tick_cnt <= tick_cnt + CNT_W'(1);
  end

  // A button is stable when both sample registers agree; a press is a stable
  // high that the debounced level has not yet recorded.
  assign agree = ~(s1 ^ s2);
  assign press = {NUM_BTNS{tick}} & s1 & s2 & ~btn_level;

  // Two-flop synchronizer every cycle; sample shift and level update on tick.
  always_ff @(posedge clk) begin
    if (rst_a_p) begin
      sync_a    <= '0;
      sync_b    <= '0;
      s1        <= '0;
      s2        <= '0;
      btn_level <= '0;
    end else begin
      sync_a <= button_in;
      sync_b <= sync_a;
      if (tick) begin
        s1        <= sync_b;
        s2        <= s1;
        btn_level <= (agree & s1) | (~agree & btn_level);
      end
    end
  end

  assign full = (count == FCNT_W'(FIFO_DEPTH));

  // Round-robin search starting just after the last granted button.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    grant_vld  = 1'b0;
    grant_id   = '0;
    grant_mask = '0;
    cand       = '0;
    if (!full) begin
      for (int k = 1; k <= NUM_BTNS; k++) begin
        cand = ID_W'((int'(last_grant) + k) % NUM_BTNS);
        if (!grant_vld && pending[cand]) begin
          grant_vld        = 1'b1;
          grant_id         = cand;
          grant_mask[cand] = 1'b1;
        end
      end
    end
  end

  // Pending requests (a same-cycle press beats its grant), pointer, overflow.
  always_ff @(posedge clk) begin
    if (rst_a_p) begin
      pending    <= '0;
      last_grant <= ID_W'(NUM_BTNS - 1);
      ovf        <= 1'b0;
    end else begin
      pending <= (pending & ~grant_mask) | press;
      if (grant_vld) last_grant <= grant_id;
      if (full && |(press & pending)) ovf <= 1'b1;
    end
  end

  assign push      = grant_vld;
  assign evt_valid = (count != '0);
  assign pop       = evt_valid && evt_ready;
  assign evt_id    = mem[rd_ptr];

  // FIFO storage write.
  // NOTE: the storage array has no reset; count and pointers alone decide
  // which entries are valid, so stale contents are never presented.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= grant_id;
  end

  // FIFO pointers and occupancy; power-of-two depth lets pointers wrap freely.
  always_ff @(posedge clk) begin
    if (rst_a_p) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + FCNT_W'(1);
        2'b01:   count <= count - FCNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_btn_event_scheduler.sv
// Directed bench for btn_event_scheduler with TICK_DIV = 8 and a 4-deep FIFO.
// Cycle numbers count rising edges after reset release (first edge -> c=1);
// sample tick edges then fall on c = 8, 16, 24, ...
module tb_btn_event_scheduler;

  logic       clk       = 1'b0;
  logic       rst_a_p   = 1'b1;
  logic [3:0] button_in = '0;
  logic       evt_ready = 1'b0;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic [3:0] btn_level;
  logic       ovf;

  int n_cmp = 0;
  int n_err = 0;
  int c     = 0;
  int got[$];
  int got_cyc[$];

  btn_event_scheduler #(
    .NUM_BTNS  (4),
    .CLK_FREQ  (8000),
    .SAMPLE_MS (1),
    .FIFO_DEPTH(4)
  ) dut (
    .clk      (clk),
    .rst_a_p  (rst_a_p),
    .button_in(button_in),
    .evt_valid(evt_valid),
    .evt_id   (evt_id),
    .evt_ready(evt_ready),
    .btn_level(btn_level),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  // Record every accepted event and the cycle it was popped in.
  always @(negedge clk) begin
    if (!rst_a_p && evt_valid && evt_ready) begin
      got.push_back(int'(evt_id));
      got_cyc.push_back(c);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      c++;
    end
  endtask

  task automatic do_reset();
    rst_a_p = 1'b1;
    step(2);
    rst_a_p = 1'b0;
    c = 0;
    got.delete();
    got_cyc.delete();
  endtask

  function automatic int got_at(int i);
    return (i < got.size()) ? got[i] : -1;
  endfunction

  function automatic int cyc_at(int i);
    return (i < got_cyc.size()) ? got_cyc[i] : -1;
  endfunction

  int lvl_c, vld_c, vld_n, fall_c;
  int hi_seen, vld_seen;
  int exp_q[$];

  initial begin
    // Single press on button 2, consumer always ready.
    do_reset();
    check("rst_valid", evt_valid, 0);
    check("rst_level", btn_level, 0);
    check("rst_ovf", ovf, 0);
    evt_ready = 1'b1;
    button_in = 4'b0100;
    lvl_c = -1; vld_c = -1; vld_n = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (btn_level[2] && lvl_c < 0) lvl_c = c;
      if (evt_valid) begin
        vld_n++;
        if (vld_c < 0) vld_c = c;
      end
    end
    check("sp_level_cycle", lvl_c, 24);
    check("sp_valid_cycle", vld_c, 25);
    check("sp_valid_len", vld_n, 1);
    check("sp_count", got.size(), 1);
    check("sp_id", got_at(0), 2);
    button_in = 4'b0000;
    fall_c = -1;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (!btn_level[2] && fall_c < 0) fall_c = c;
    end
    check("sp_fall_cycle", fall_c, 64);
    check("sp_release_noevt", got.size(), 1);

    // Glitches on button 1: one between ticks, one straddling a tick edge.
    do_reset();
    evt_ready = 1'b1;
    hi_seen = 0; vld_seen = 0;
    step(8);
    button_in = 4'b0010;
    step(3);
    button_in = 4'b0000;
    step(10);
    button_in = 4'b0010;
    step(3);
    button_in = 4'b0000;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (btn_level[1]) hi_seen = 1;
      if (evt_valid) vld_seen = 1;
    end
    check("gl_level", hi_seen, 0);
    check("gl_valid", vld_seen, 0);
    check("gl_events", got.size(), 0);
    check("gl_ovf", ovf, 0);

    // Simultaneous press of 0, 1, 3, twice.
    do_reset();
    evt_ready = 1'b1;
    button_in = 4'b1011;
    step(40);
    check("sim1_count", got.size(), 3);
    check("sim1_id0", got_at(0), 0);
    check("sim1_id1", got_at(1), 1);
    check("sim1_id2", got_at(2), 3);
    check("sim1_cyc0", cyc_at(0), 25);
    check("sim1_cyc1", cyc_at(1), 26);
    check("sim1_cyc2", cyc_at(2), 27);
    button_in = 4'b0000;
    step(40);
    check("sim_release_noevt", got.size(), 3);
    got.delete();
    got_cyc.delete();
    button_in = 4'b1011;
    step(48);
    check("sim2_count", got.size(), 3);
    check("sim2_id0", got_at(0), 0);
    check("sim2_id1", got_at(1), 1);
    check("sim2_id2", got_at(2), 3);

    // Backpressure: fill the FIFO, leave button 0 pending, then overflow.
    do_reset();
    evt_ready = 1'b0;
    button_in = 4'b1111;
    step(48);
    check("bp_full_valid", evt_valid, 1);
    check("bp_full_head", evt_id, 0);
    button_in = 4'b0000;
    step(48);
    check("bp_release_level", btn_level, 0);
    button_in = 4'b0001;
    step(48);
    check("bp_pending_level", btn_level, 1);
    check("bp_no_ovf_yet", ovf, 0);
    button_in = 4'b0000;
    step(48);
    button_in = 4'b0001;
    step(48);
    check("bp_ovf", ovf, 1);
    check("bp_head_hold", evt_id, 0);
    check("bp_no_pop", got.size(), 0);
    evt_ready = 1'b1;
    step(16);
    check("bp_drain_count", got.size(), 5);
    check("bp_drain0", got_at(0), 0);
    check("bp_drain1", got_at(1), 1);
    check("bp_drain2", got_at(2), 2);
    check("bp_drain3", got_at(3), 3);
    check("bp_drain4", got_at(4), 0);
    check("bp_drain_empty", evt_valid, 0);
    check("bp_ovf_sticky", ovf, 1);

    // Handshake hold: ready toggles, head must hold while ready is low.
    do_reset();
    evt_ready = 1'b0;
    button_in = 4'b1111;
    step(40);
    exp_q = '{0, 1, 2, 3};
    for (int i = 0; i < 8; i++) begin
      evt_ready = (i % 2 == 1);
      check("hs_valid", evt_valid, 1);
      check("hs_id", evt_id, exp_q[0]);
      step(1);
      if (evt_ready) void'(exp_q.pop_front());
    end
    evt_ready = 1'b0;
    check("hs_pops", got.size(), 4);
    check("hs_empty", evt_valid, 0);

    // Mid-operation reset with two queued and one pending.
    do_reset();
    evt_ready = 1'b0;
    button_in = 4'b0111;
    step(26);
    check("mr_pre_valid", evt_valid, 1);
    rst_a_p   = 1'b1;
    button_in = 4'b0000;
    step(1);
    rst_a_p = 1'b0;
    check("mr_valid", evt_valid, 0);
    check("mr_ovf", ovf, 0);
    check("mr_level", btn_level, 0);
    c = 0;
    got.delete();
    got_cyc.delete();
    evt_ready = 1'b1;
    step(40);
    check("mr_discard", got.size(), 0);
    button_in = 4'b1001;
    step(40);
    check("mr_count", got.size(), 2);
    check("mr_first", got_at(0), 0);
    check("mr_second", got_at(1), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
